mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one single-port unified memory between the CPU's instruction-fetch path and its load/store path. It sits between the PC/fetch logic and the data-access logic on one side and the memory on the other. It serialises their requests with data-first priority and a starvation guard, and keeps exactly one memory transaction outstanding. A watchdog aborts transactions the memory never completes.

## Interface

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (strobe width DATA_W/8)
- MAX_D_STREAK, 4, consecutive data grants allowed while fetch waits
- TIMEOUT, 255, cycles without memory progress before abort (8-bit counter)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted by memory (pulse)
- if_rvalid  out  1  fetch data valid / completion (pulse)
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  data request; held with payload until d_gnt
- d_we  in  1  1 = store
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  byte enables
- d_gnt  out  1  data accepted (pulse)
- d_rvalid  out  1  load data / store ack (pulse)
- d_rdata  out  DATA_W  load data
- mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/1/ADDR_W/DATA_W/DATA_W/8  memory command, registered
- mem_ready  in  1  memory accepts command this cycle
- mem_rvalid  in  1  completion (reads and writes)
- mem_rdata  in  DATA_W  read data
- err  out  1  timeout abort (pulse)
- err_is_data  out  1  owner of aborted transaction, valid with err

## Operation

- States: IDLE, REQ, WAIT. Owner register: INST or DATA.
- IDLE: if d_req and not (streak == MAX_D_STREAK and if_req), pick DATA; else if if_req, pick INST. Latch owner and payload into mem_* registers; go to REQ. No request: stay.
- Fetch commands drive mem_we=0 and mem_wstrb=0.
- Streak counter: +1 on each DATA pick while if_req=1. Clears on INST pick, and on a DATA pick while if_req=0. Saturates at MAX_D_STREAK.
- REQ: mem_req=1. When mem_ready=1, pulse owner's gnt combinationally in that cycle; go to WAIT.
- WAIT: mem_req=0. When mem_rvalid=1, pulse owner's rvalid and pass mem_rdata combinationally to owner's rdata; go to IDLE.
- Non-owner gnt and rvalid stay 0. rdata outputs are don't-care when rvalid=0.
- Watchdog: clears on entry to REQ and WAIT; increments each cycle in REQ/WAIT without the awaited event. On reaching TIMEOUT: err pulse, err_is_data=owner, return to IDLE.
  - Abort in WAIT: owner's rvalid also pulses with rdata=0, so the requester sees completion.
  - Abort in REQ: no gnt is issued; the requester keeps req high and the request is re-arbitrated.
- mem_rvalid in IDLE or REQ (late or stray) is ignored.
- Reset, including mid-transaction: state IDLE, all outputs 0, streak 0, watchdog 0, owner INST.

## Timing

- Minimum transaction: 3 cycles. Cycle N IDLE picks; cycle N+1 REQ with mem_ready=1 pulses gnt; cycle N+2 WAIT with mem_rvalid=1 pulses rvalid.
- Back-to-back transactions pass through IDLE for one cycle. Peak rate: 1 transaction per 3 cycles.
- Requests asserted in REQ/WAIT are sampled only in the next IDLE.
- Simultaneous if_req and d_req in IDLE with streak < MAX_D_STREAK: DATA wins.
- mem_* outputs are constant through REQ.

## Test plan

- Single fetch, if_addr=0x100, mem_ready and mem_rvalid at first opportunity, mem_rdata=0x00000013 -> mem_addr=0x100 with mem_we=0; if_gnt at cycle 2; if_rvalid with if_rdata=0x13 at cycle 3.
- Simultaneous if_req and d_req (store 0xDEADBEEF to 0x200, wstrb=0xF) -> store issued first, mem_we=1; fetch follows after store completion.
- d_req held continuously with if_req -> exactly 4 data transactions, then one fetch, then data resumes.
- mem_ready held 0 for 300 cycles -> err pulses at watchdog count 255 with correct err_is_data; no gnt; request re-issued from IDLE.
- mem_rvalid withheld in WAIT -> err and owner rvalid pulse together with rdata=0. A late mem_rvalid afterwards produces no pulse.
- rst_n asserted in WAIT -> all outputs 0 immediately. After release, a pending if_req is re-arbitrated from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module : mem_port_arbiter_if
// Brief  : Fetch, data and memory handshake bundle for mem_port_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch side
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;
  // load/store side
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_wstrb;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;
  // memory side
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic                  mem_ready;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;
  // watchdog abort
  logic                  err;
  logic                  err_is_data;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output err, err_is_data
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    output mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  err, err_is_data
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Data-first fetch/data arbiter for a single-port memory with a
//          starvation guard and a transaction watchdog.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus
);

  localparam int         STRB_W      = DATA_W / 8;
  localparam int         STREAK_W    = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                state;
  logic                  owner_data;
  logic [STREAK_W-1:0]   streak;
  logic [7:0]            wdog;

  logic                  pick_data;
  logic                  pick_inst;
  logic                  in_req;
  logic                  in_wait;
  logic                  wdog_expired;
  logic                  abort;
  logic                  grant_ev;
  logic                  done_ev;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic [STRB_W-1:0]     sel_wstrb;
  logic [DATA_W-1:0]     owner_rdata;

  // Fetch wins over data only once data has taken MAX_D_STREAK grants in a row.
  assign pick_data = bus.d_req && !((streak == STREAK_MAX) && bus.if_req);
  assign pick_inst = !pick_data && bus.if_req;

  assign sel_addr  = pick_data ? bus.d_addr  : bus.if_addr;
  assign sel_wdata = pick_data ? bus.d_wdata : '0;
  assign sel_wstrb = pick_data ? bus.d_wstrb : '0;

  assign in_req       = (state == S_REQ);
  assign in_wait      = (state == S_WAIT);
  assign wdog_expired = (wdog == TIMEOUT_CNT);

  // A memory event arriving in the expiry cycle still counts as progress.
  assign abort    = wdog_expired &&
                    ((in_req && !bus.mem_ready) || (in_wait && !bus.mem_rvalid));
  assign grant_ev = in_req && bus.mem_ready;
  assign done_ev  = in_wait && (bus.mem_rvalid || abort);

  // Aborted reads complete with zero data.
  assign owner_rdata = (in_wait && bus.mem_rvalid) ? bus.mem_rdata : '0;

  assign bus.if_gnt      = grant_ev && !owner_data;
  assign bus.d_gnt       = grant_ev &&  owner_data;
  assign bus.if_rvalid   = done_ev  && !owner_data;
  assign bus.d_rvalid    = done_ev  &&  owner_data;
  assign bus.if_rdata    = owner_data ? '0 : owner_rdata;
  assign bus.d_rdata     = owner_data ? owner_rdata : '0;
  assign bus.err         = abort;
  assign bus.err_is_data = abort && owner_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      owner_data    <= 1'b0;
      streak        <= '0;
      wdog          <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_data || pick_inst) begin
            owner_data    <= pick_data;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= pick_data && bus.d_we;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            bus.mem_wstrb <= sel_wstrb;
            wdog          <= '0;
            state         <= S_REQ;
            if (pick_data && bus.if_req) begin
              if (streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
              end
            end else begin
              streak <= '0;
            end
          end
        end

        S_REQ: begin
          if (bus.mem_ready) begin
            bus.mem_req <= 1'b0;
            wdog        <= '0;
            state       <= S_WAIT;
          end else if (abort) begin
            bus.mem_req <= 1'b0;
            wdog        <= '0;
            state       <= S_IDLE;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end

        S_WAIT: begin
          if (done_ev) begin
            wdog  <= '0;
            state <= S_IDLE;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end

        default: begin
          bus.mem_req <= 1'b0;
          wdog        <= '0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
